i2s_rx: RTL and testbench

Oversampling I2S receiver: the receive-side counterpart of the board's I2S transmitter path. Samples an external I2S bus (BCK/WS/DATA) in the AMCLK_i domain and recovers it into parallel left/right PCM words with a one-cycle valid strobe. It feeds the audio capture and ASRC logic with the same word format the transmitter consumes. It also detects loss of bit clock.

---
 rtl/i2s_rx_if.sv | 33 +++
 rtl/i2s_rx.sv | 137 +++++++++++++
 tb/tb_i2s_rx.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// i2s_rx_if: external I2S serial bus plus the recovered PCM word outputs.
// master drives the serial lines, slave is the receiver.
interface i2s_rx_if #(
   parameter int I2S_DATA_BITS = 24
);
   logic                     I2S_BCK_i;
   logic                     I2S_WS_i;
   logic                     I2S_DATA_i;
   logic [I2S_DATA_BITS-1:0] APSDATA_LEFT_o;
   logic [I2S_DATA_BITS-1:0] APSDATA_RIGHT_o;
   logic                     APDATA_VALID_o;
   logic                     LOCKED_o;

   modport master (
      output I2S_BCK_i,
      output I2S_WS_i,
      output I2S_DATA_i,
      input  APSDATA_LEFT_o,
      input  APSDATA_RIGHT_o,
      input  APDATA_VALID_o,
      input  LOCKED_o
   );

   modport slave (
      input  I2S_BCK_i,
      input  I2S_WS_i,
      input  I2S_DATA_i,
      output APSDATA_LEFT_o,
      output APSDATA_RIGHT_o,
      output APDATA_VALID_o,
      output LOCKED_o
   );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S receiver, recovers L/R PCM words in the AMCLK_i
// domain, pulses a valid strobe per frame and drops lock on BCK loss.
module i2s_rx #(
   parameter int I2S_DATA_BITS  = 24,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic   AMCLK_i,
   input logic   reset_n,
   i2s_rx_if.slave bus
);
   localparam int W  = I2S_DATA_BITS;
   localparam int CW = $clog2(W) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_t;

   logic          bck_s1_q, bck_s1_d, bck_s_q, bck_s_d;
   logic          ws_s1_q, ws_s1_d, ws_s_q, ws_s_d;
   logic          dat_s1_q, dat_s1_d, dat_s_q, dat_s_d;
   logic          bck_prev_q, bck_prev_d;
   logic          ws_d_q, ws_d_d, ws_dd_q, ws_dd_d;
   logic [W-1:0]  shreg_q, shreg_d;
   logic [CW-1:0] bit_ctr_q, bit_ctr_d;
   logic [W-1:0]  left_hold_q, left_hold_d;
   logic [W-1:0]  left_q, left_d, right_q, right_d;
   logic          valid_q, valid_d, locked_q, locked_d;
   logic [TW-1:0] idle_q, idle_d;
   state_t        state_q, state_d;
   logic          rise, word_start;

   assign rise       = bck_s_q & ~bck_prev_q;
   assign word_start = ws_d_q ^ ws_dd_q;

   always_comb begin
      bck_s1_d    = bus.I2S_BCK_i;
      bck_s_d     = bck_s1_q;
      ws_s1_d     = bus.I2S_WS_i;
      ws_s_d      = ws_s1_q;
      dat_s1_d    = bus.I2S_DATA_i;
      dat_s_d     = dat_s1_q;
      bck_prev_d  = bck_s_q;
      ws_d_d      = ws_d_q;
      ws_dd_d     = ws_dd_q;
      shreg_d     = shreg_q;
      bit_ctr_d   = bit_ctr_q;
      left_hold_d = left_hold_q;
      left_d      = left_q;
      right_d     = right_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      idle_d      = idle_q;
      state_d     = state_q;
      if (rise) begin
         ws_d_d  = ws_s_q;
         ws_dd_d = ws_d_q;
         idle_d  = '0;
         if (word_start) begin
            // shreg_q still holds the completed word of the other channel
            shreg_d        = '0;
            shreg_d[W-1]   = dat_s_q;
            bit_ctr_d      = CW'(1);
            case (state_q)
               UNLOCKED: if (!ws_d_q) state_d = LEFT;
               LEFT: if (ws_d_q) begin
                  state_d     = RIGHT;
                  left_hold_d = shreg_q;
               end
               RIGHT: if (!ws_d_q) begin
                  state_d  = LEFT;
                  left_d   = left_hold_q;
                  right_d  = shreg_q;
                  valid_d  = 1'b1;
                  locked_d = 1'b1;
               end
               default: state_d = UNLOCKED;
            endcase
         end else if (bit_ctr_q < CW'(W)) begin
            for (int i = 0; i < W; i++) begin
               if (CW'(W - 1 - i) == bit_ctr_q) shreg_d[i] = dat_s_q;
            end
            bit_ctr_d = bit_ctr_q + CW'(1);
         end
      end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d  = UNLOCKED;
         locked_d = 1'b0;
      end else begin
         idle_d = idle_q + TW'(1);
      end
   end

   always_ff @(posedge AMCLK_i or negedge reset_n) begin
      if (!reset_n) begin
         bck_s1_q    <= 1'b0;
         bck_s_q     <= 1'b0;
         ws_s1_q     <= 1'b0;
         ws_s_q      <= 1'b0;
         dat_s1_q    <= 1'b0;
         dat_s_q     <= 1'b0;
         bck_prev_q  <= 1'b0;
         ws_d_q      <= 1'b0;
         ws_dd_q     <= 1'b0;
         shreg_q     <= '0;
         bit_ctr_q   <= '0;
         left_hold_q <= '0;
         left_q      <= '0;
         right_q     <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         idle_q      <= '0;
         state_q     <= UNLOCKED;
      end else begin
         bck_s1_q    <= bck_s1_d;
         bck_s_q     <= bck_s_d;
         ws_s1_q     <= ws_s1_d;
         ws_s_q      <= ws_s_d;
         dat_s1_q    <= dat_s1_d;
         dat_s_q     <= dat_s_d;
         bck_prev_q  <= bck_prev_d;
         ws_d_q      <= ws_d_d;
         ws_dd_q     <= ws_dd_d;
         shreg_q     <= shreg_d;
         bit_ctr_q   <= bit_ctr_d;
         left_hold_q <= left_hold_d;
         left_q      <= left_d;
         right_q     <= right_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         idle_q      <= idle_d;
         state_q     <= state_d;
      end
   end

   assign bus.APSDATA_LEFT_o  = left_q;
   assign bus.APSDATA_RIGHT_o = right_q;
   assign bus.APDATA_VALID_o  = valid_q;
   assign bus.LOCKED_o        = locked_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives I2S bit streams and checks recovered words, strobe
// timing, lock and timeout against a run-based stream model.
module tb_i2s_rx;
   localparam int W = 24;
   localparam int T = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   i2s_rx_if #(.I2S_DATA_BITS(W)) bus ();

   i2s_rx #(.I2S_DATA_BITS(W), .TIMEOUT_CYCLES(T)) dut (
      .AMCLK_i (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   logic [W-1:0] ml_q[$], mr_q[$];
   int           mc_q[$];
   bit           mlp_q[$], mlc_q[$];
   bit           prev_valid = 1'b0, prev_lock = 1'b0;

   always @(posedge clk) begin
      #1;
      if (bus.APDATA_VALID_o === 1'b1) begin
         ml_q.push_back(bus.APSDATA_LEFT_o);
         mr_q.push_back(bus.APSDATA_RIGHT_o);
         mc_q.push_back(cyc);
         mlp_q.push_back(prev_lock);
         mlc_q.push_back(bus.LOCKED_o);
         tests++;
         assert (prev_valid === 1'b0) else begin
            fails++;
            $error("FAIL valid_width: got 2+ cycles want 1 at cycle %0d", cyc);
         end
      end
      prev_valid = bus.APDATA_VALID_o;
      prev_lock  = bus.LOCKED_o;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: run did not complete, got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   bit           s_ch[$], s_bt[$];
   logic [W-1:0] el_q[$], er_q[$];
   int           es_q[$];
   int           rise_cyc[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] get_l(input int i);
      return (i < ml_q.size()) ? ml_q[i] : 'x;
   endfunction

   function automatic logic [W-1:0] get_r(input int i);
      return (i < mr_q.size()) ? mr_q[i] : 'x;
   endfunction

   function automatic void new_stream();
      s_ch.delete();
      s_bt.delete();
   endfunction

   // val is left-justified: bit 31 goes out first
   function automatic void add_word(input bit ch, input logic [31:0] val,
                                    input int len);
      for (int i = 0; i < len; i++) begin
         s_ch.push_back(ch);
         s_bt.push_back(val[31-i]);
      end
   endfunction

   // Split stream into channel runs; a run's word is its first W bits,
   // zero-padded. A left run emits the last left/right pair once a full
   // left+right has followed an earlier left start.
   function automatic void model(input bit init_ch);
      bit           prev = init_ch;
      bit           hl = 1'b0, hr = 1'b0;
      logic [W-1:0] lw = '0, rw = '0, w;
      int           k, j;
      el_q.delete();
      er_q.delete();
      es_q.delete();
      for (int t = 0; t < s_ch.size(); t++) begin
         if (s_ch[t] != prev) begin
            w = '0;
            k = 0;
            j = t;
            while (j < s_ch.size() && s_ch[j] == s_ch[t] && k < W) begin
               w[W-1-k] = s_bt[j];
               k++;
               j++;
            end
            if (s_ch[t] == 1'b0) begin
               if (hl && hr) begin
                  el_q.push_back(lw);
                  er_q.push_back(rw);
                  es_q.push_back(t);
               end
               hl = 1'b1;
               hr = 1'b0;
               lw = w;
            end else if (hl) begin
               hr = 1'b1;
               rw = w;
            end
         end
         prev = s_ch[t];
      end
   endfunction

   // BCK = AMCLK/4; WS leads its data bit by one BCK
   task automatic drive();
      rise_cyc.delete();
      for (int t = 0; t < s_ch.size(); t++) begin
         bus.I2S_BCK_i  = 1'b0;
         bus.I2S_DATA_i = s_bt[t];
         bus.I2S_WS_i   = (t + 1 < s_ch.size()) ? s_ch[t+1] : s_ch[t];
         repeat (2) @(negedge clk);
         bus.I2S_BCK_i = 1'b1;
         rise_cyc.push_back(cyc + 1);
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic run_stream(input bit init_ch, input string tag);
      ml_q.delete();
      mr_q.delete();
      mc_q.delete();
      mlp_q.delete();
      mlc_q.delete();
      model(init_ch);
      drive();
      repeat (8) @(negedge clk);
      chk($sformatf("%s count", tag), ml_q.size(), el_q.size());
      for (int i = 0; i < el_q.size() && i < ml_q.size(); i++) begin
         chk($sformatf("%s L%0d", tag, i), ml_q[i], el_q[i]);
         chk($sformatf("%s R%0d", tag, i), mr_q[i], er_q[i]);
         chk($sformatf("%s lat%0d", tag, i), mc_q[i], rise_cyc[es_q[i]] + 2);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.I2S_BCK_i  = 1'b0;
      bus.I2S_WS_i   = 1'b0;
      bus.I2S_DATA_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic frames(input logic [31:0] l, input logic [31:0] r,
                         input int len, input int n);
      for (int f = 0; f < n; f++) begin
         add_word(1'b0, l, len);
         add_word(1'b1, r, len);
      end
   endtask

   initial begin
      int           m, nv, len;
      logic [W-1:0] hl, hr;
      bus.I2S_BCK_i  = 1'b0;
      bus.I2S_WS_i   = 1'b0;
      bus.I2S_DATA_i = 1'b0;
      do_reset();
      chk("rst left", bus.APSDATA_LEFT_o, 0);
      chk("rst right", bus.APSDATA_RIGHT_o, 0);
      chk("rst valid", bus.APDATA_VALID_o, 0);
      chk("rst locked", bus.LOCKED_o, 0);

      new_stream();
      add_word(1'b1, 32'h0, 3);
      frames(32'h12345600, 32'hABCDEF00, 32, 3);
      run_stream(1'b0, "f64");
      chk("f64 L0 val", get_l(0), 24'h123456);
      chk("f64 R1 val", get_r(1), 24'hABCDEF);
      chk("f64 lock_before", (mlp_q.size() > 0) ? mlp_q[0] : 1'b1, 0);
      chk("f64 lock_at", (mlc_q.size() > 0) ? mlc_q[0] : 1'b0, 1);

      do_reset();
      new_stream();
      add_word(1'b1, 32'h0, 3);
      frames(32'h80010000, 32'h7FFE0000, 16, 3);
      run_stream(1'b0, "f32");
      chk("f32 L0 val", get_l(0), 24'h800100);
      chk("f32 R0 val", get_r(0), 24'h7FFE00);

      do_reset();
      new_stream();
      add_word(1'b1, 32'h0, 3);
      frames(32'h89ABCDEF, 32'h01234567, 32, 3);
      run_stream(1'b0, "trunc");
      chk("trunc L0 val", get_l(0), 24'h89ABCD);
      chk("trunc R0 val", get_r(0), 24'h012345);

      m  = rise_cyc[rise_cyc.size()-1] + 2;
      hl = el_q[el_q.size()-1];
      hr = er_q[er_q.size()-1];
      nv = ml_q.size();
      while (cyc < m + T - 1) @(negedge clk);
      chk("to lock_1023", bus.LOCKED_o, 1);
      @(negedge clk);
      chk("to lock_1024", bus.LOCKED_o, 0);
      chk("to hold L", bus.APSDATA_LEFT_o, hl);
      chk("to hold R", bus.APSDATA_RIGHT_o, hr);
      chk("to no valid", ml_q.size(), nv);

      new_stream();
      add_word(1'b1, 32'h0, 3);
      frames($urandom, $urandom, 32, 2);
      add_word(1'b0, $urandom, 2);
      run_stream(1'b1, "restart");
      chk("restart lock_before", (mlp_q.size() > 0) ? mlp_q[0] : 1'b1, 0);

      do_reset();
      new_stream();
      add_word(1'b1, 32'h0, 3);
      frames($urandom, $urandom, 32, 1);
      add_word(1'b0, $urandom, 32);
      add_word(1'b1, $urandom, 10);
      run_stream(1'b0, "pre_rst");
      #2 rst_n = 1'b0;
      #1;
      chk("arst left", bus.APSDATA_LEFT_o, 0);
      chk("arst right", bus.APSDATA_RIGHT_o, 0);
      chk("arst valid", bus.APDATA_VALID_o, 0);
      chk("arst locked", bus.LOCKED_o, 0);
      bus.I2S_BCK_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      new_stream();
      add_word(1'b1, 32'h0, 3);
      frames($urandom, $urandom, 32, 1);
      add_word(1'b0, $urandom, 2);
      run_stream(1'b0, "post_rst");

      for (int it = 0; it < 5; it++) begin
         do_reset();
         len = (it == 0) ? 1 : $urandom_range(1, 32);
         new_stream();
         add_word(1'b1, $urandom, 3);
         for (int f = 0; f < 4; f++) begin
            add_word(1'b0, $urandom, len);
            add_word(1'b1, $urandom, len);
         end
         add_word(1'b0, $urandom, len);
         run_stream(1'b0, $sformatf("rnd%0d_len%0d", it, len));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
